// File: rtl/mc_ctrl_v2.sv
// rtl/mc_ctrl_v2.sv - multicycle MIPS control unit with memory handshake, bus watchdog and precise exceptions
//
// Optional feature macro: MC_CTRL_PERF_EN (retired-instruction and memory-stall counters)
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   zero, overflow              ALU flags (overflow checked in EX_R/EX_I for add/sub/addi)
//   MIO_ready                   memory/IO handshake, access completes in the cycle it is high
//   inst_in[31:0]               instruction register contents
//   MemRead, MemWrite, CPU_MIO, lorD, IRWrite          memory/fetch strobes
//   RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch, S datapath strobes (S = shift-amount select)
//   RegDst, MemtoReg, ALUSrcB, PCSource [1:0]          datapath mux selects
//   ALU_operation[2:0]          ALU function
//   state_out[4:0]              current state encoding
//   exc_valid, exc_cause[1:0]   exception pulse and sticky cause
//   perf_retired, perf_stall    performance counters (constant 0 without MC_CTRL_PERF_EN)
module mc_ctrl_v2 #(
    parameter int TIMEOUT_W   = 8,
    parameter int TIMEOUT_MAX = 255,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              zero,
    input  logic              overflow,
    input  logic              MIO_ready,
    input  logic [31:0]       inst_in,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              CPU_MIO,
    output logic              lorD,
    output logic              IRWrite,
    output logic              RegWrite,
    output logic              ALUSrcA,
    output logic              PCWrite,
    output logic              PCWriteCond,
    output logic              Branch,
    output logic              S,
    output logic [1:0]        RegDst,
    output logic [1:0]        MemtoReg,
    output logic [1:0]        ALUSrcB,
    output logic [1:0]        PCSource,
    output logic [2:0]        ALU_operation,
    output logic [4:0]        state_out,
    output logic              exc_valid,
    output logic [1:0]        exc_cause,
    output logic [PERF_W-1:0] perf_retired,
    output logic [PERF_W-1:0] perf_stall
);

    typedef enum logic [4:0] {
        S_IF     = 5'd0,
        S_ID     = 5'd1,
        S_EX_R   = 5'd2,
        S_EX_MEM = 5'd3,
        S_EX_I   = 5'd4,
        S_LUI_WB = 5'd5,
        S_EX_BEQ = 5'd6,
        S_EX_BNE = 5'd7,
        S_EX_JR  = 5'd8,
        S_EX_JAL = 5'd9,
        S_EXE_J  = 5'd10,
        S_MEM_RD = 5'd11,
        S_MEM_WD = 5'd12,
        S_WB_R   = 5'd13,
        S_WB_I   = 5'd14,
        S_WB_LW  = 5'd15,
        S_EX_JALR= 5'd16,
        S_EXC    = 5'd17
    } state_t;

    typedef enum logic [3:0] {
        D_RSVD, D_R, D_I, D_LUI, D_LW, D_SW, D_BEQ, D_BNE, D_J, D_JAL, D_JR, D_JALR
    } dec_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] CAUSE_RSVD = 2'b01;
    localparam logic [1:0] CAUSE_OVF  = 2'b10;
    localparam logic [1:0] CAUSE_BUS  = 2'b11;

    state_t                r_state;
    state_t                w_next;
    logic [TIMEOUT_W-1:0]  r_wdog;
    logic [1:0]            r_exc_cause;
    logic [1:0]            w_exc_code;
    dec_t                  w_dec;
    logic [2:0]            w_alu_dec;
    logic                  w_ovf_chk;
    logic                  w_shift;
    logic                  w_mem_state;
    logic                  w_wait;
    logic                  w_timeout;
    logic [5:0]            w_op;
    logic [5:0]            w_fn;
    logic                  w_unused;

    assign w_op     = inst_in[31:26];
    assign w_fn     = inst_in[5:0];
    // Control decisions never look at zero or the register/immediate fields.
    assign w_unused = &{1'b0, zero, inst_in[25:6]};

    // Instruction class, ALU function and whether overflow must trap.
    always_comb begin
        w_dec     = D_RSVD;
        w_alu_dec = ALU_ADD;
        w_ovf_chk = 1'b0;
        w_shift   = 1'b0;
        case (w_op)
            6'h00: begin
                case (w_fn)
                    6'h20: begin w_dec = D_R; w_alu_dec = ALU_ADD; w_ovf_chk = 1'b1; end
                    6'h22: begin w_dec = D_R; w_alu_dec = ALU_SUB; w_ovf_chk = 1'b1; end
                    6'h24: begin w_dec = D_R; w_alu_dec = ALU_AND; end
                    6'h25: begin w_dec = D_R; w_alu_dec = ALU_OR;  end
                    6'h26: begin w_dec = D_R; w_alu_dec = ALU_XOR; end
                    6'h27: begin w_dec = D_R; w_alu_dec = ALU_NOR; end
                    6'h2A: begin w_dec = D_R; w_alu_dec = ALU_SLT; end
                    6'h02: begin w_dec = D_R; w_alu_dec = ALU_SRL; w_shift = 1'b1; end
                    6'h08: w_dec = D_JR;
                    6'h09: w_dec = D_JALR;
                    default: w_dec = D_RSVD;
                endcase
            end
            6'h08: begin w_dec = D_I; w_alu_dec = ALU_ADD; w_ovf_chk = 1'b1; end
            6'h0C: begin w_dec = D_I; w_alu_dec = ALU_AND; end
            6'h0D: begin w_dec = D_I; w_alu_dec = ALU_OR;  end
            6'h0E: begin w_dec = D_I; w_alu_dec = ALU_XOR; end
            6'h0A: begin w_dec = D_I; w_alu_dec = ALU_SLT; end
            6'h0F: w_dec = D_LUI;
            6'h23: w_dec = D_LW;
            6'h2B: w_dec = D_SW;
            6'h04: w_dec = D_BEQ;
            6'h05: w_dec = D_BNE;
            6'h02: w_dec = D_J;
            6'h03: w_dec = D_JAL;
            default: w_dec = D_RSVD;
        endcase
    end

    assign w_mem_state = (r_state == S_IF) || (r_state == S_MEM_RD) || (r_state == S_MEM_WD);
    assign w_wait      = w_mem_state && !MIO_ready;
    // A completing handshake always wins: timeout only fires on a cycle that is still waiting.
    assign w_timeout   = w_wait && (r_wdog == TIMEOUT_W'(TIMEOUT_MAX));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IF;
            r_wdog      <= '0;
            r_exc_cause <= 2'b00;
        end else begin
            r_state <= w_next;
            if (w_wait && !w_timeout) begin
                r_wdog <= r_wdog + TIMEOUT_W'(1);
            end else begin
                r_wdog <= '0;
            end
            if (w_next == S_EXC && r_state != S_EXC) begin
                r_exc_cause <= w_exc_code;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_exc_code = 2'b00;
        case (r_state)
            S_IF: begin
                if (MIO_ready) begin
                    w_next = S_ID;
                end else if (w_timeout) begin
                    w_next     = S_EXC;
                    w_exc_code = CAUSE_BUS;
                end
            end
            S_ID: begin
                case (w_dec)
                    D_R:    w_next = S_EX_R;
                    D_I:    w_next = S_EX_I;
                    D_LUI:  w_next = S_LUI_WB;
                    D_LW:   w_next = S_EX_MEM;
                    D_SW:   w_next = S_EX_MEM;
                    D_BEQ:  w_next = S_EX_BEQ;
                    D_BNE:  w_next = S_EX_BNE;
                    D_J:    w_next = S_EXE_J;
                    D_JAL:  w_next = S_EX_JAL;
                    D_JR:   w_next = S_EX_JR;
                    D_JALR: w_next = S_EX_JALR;
                    default: begin
                        w_next     = S_EXC;
                        w_exc_code = CAUSE_RSVD;
                    end
                endcase
            end
            S_EX_R: begin
                if (overflow && w_ovf_chk) begin
                    w_next     = S_EXC;
                    w_exc_code = CAUSE_OVF;
                end else begin
                    w_next = S_WB_R;
                end
            end
            S_EX_I: begin
                if (overflow && w_ovf_chk) begin
                    w_next     = S_EXC;
                    w_exc_code = CAUSE_OVF;
                end else begin
                    w_next = S_WB_I;
                end
            end
            S_EX_MEM: w_next = (w_dec == D_LW) ? S_MEM_RD : S_MEM_WD;
            S_MEM_RD: begin
                if (MIO_ready) begin
                    w_next = S_WB_LW;
                end else if (w_timeout) begin
                    w_next     = S_EXC;
                    w_exc_code = CAUSE_BUS;
                end
            end
            S_MEM_WD: begin
                if (MIO_ready) begin
                    w_next = S_IF;
                end else if (w_timeout) begin
                    w_next     = S_EXC;
                    w_exc_code = CAUSE_BUS;
                end
            end
            S_EX_JAL: w_next = S_EXE_J;
            default:  w_next = S_IF;
        endcase
    end

    always_comb begin
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        CPU_MIO       = 1'b0;
        lorD          = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        Branch        = 1'b0;
        S             = 1'b0;
        RegDst        = 2'b00;
        MemtoReg      = 2'b00;
        ALUSrcB       = 2'b00;
        PCSource      = 2'b00;
        ALU_operation = 3'b000;
        exc_valid     = 1'b0;
        case (r_state)
            S_IF: begin
                MemRead       = 1'b1;
                CPU_MIO       = 1'b1;
                ALUSrcB       = 2'b01;
                ALU_operation = ALU_ADD;
                IRWrite       = MIO_ready;
                PCWrite       = MIO_ready;
            end
            S_ID: begin
                ALUSrcB       = 2'b11;
                ALU_operation = ALU_ADD;
            end
            S_EX_R: begin
                ALUSrcA       = 1'b1;
                ALU_operation = w_alu_dec;
                S             = w_shift;
            end
            S_EX_MEM: begin
                ALUSrcA       = 1'b1;
                ALUSrcB       = 2'b10;
                ALU_operation = ALU_ADD;
            end
            S_EX_I: begin
                ALUSrcA       = 1'b1;
                ALUSrcB       = 2'b10;
                ALU_operation = w_alu_dec;
            end
            S_LUI_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b10;
            end
            S_EX_BEQ: begin
                ALUSrcA       = 1'b1;
                ALU_operation = ALU_SUB;
                PCWriteCond   = 1'b1;
                Branch        = 1'b1;
                PCSource      = 2'b01;
            end
            S_EX_BNE: begin
                ALUSrcA       = 1'b1;
                ALU_operation = ALU_SUB;
                PCWriteCond   = 1'b1;
                PCSource      = 2'b01;
            end
            S_EX_JR: begin
                ALUSrcA       = 1'b1;
                ALU_operation = ALU_ADD;
                PCWrite       = 1'b1;
            end
            S_EX_JAL: begin
                RegWrite = 1'b1;
                RegDst   = 2'b10;
                MemtoReg = 2'b11;
            end
            S_EXE_J: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                CPU_MIO = 1'b1;
                lorD    = 1'b1;
            end
            S_MEM_WD: begin
                MemWrite = 1'b1;
                CPU_MIO  = 1'b1;
                lorD     = 1'b1;
            end
            S_WB_R: begin
                RegWrite = 1'b1;
                RegDst   = 2'b01;
            end
            S_WB_I: begin
                RegWrite = 1'b1;
            end
            S_WB_LW: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b01;
            end
            S_EX_JALR: begin
                ALUSrcA       = 1'b1;
                ALU_operation = ALU_ADD;
                PCWrite       = 1'b1;
                RegWrite      = 1'b1;
                RegDst        = 2'b01;
                MemtoReg      = 2'b11;
            end
            S_EXC: begin
                PCWrite   = 1'b1;
                PCSource  = 2'b11;
                exc_valid = 1'b1;
            end
            default: begin
                MemRead = 1'b0;
            end
        endcase
    end

    assign state_out = r_state;
    assign exc_cause = r_exc_cause;

`ifdef MC_CTRL_PERF_EN
    logic [PERF_W-1:0] r_perf_retired;
    logic [PERF_W-1:0] r_perf_stall;

    // An instruction retires when control returns to IF by any path other than the exception state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_retired <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_next == S_IF && r_state != S_IF && r_state != S_EXC) begin
                r_perf_retired <= r_perf_retired + PERF_W'(1);
            end
            if (w_wait) begin
                r_perf_stall <= r_perf_stall + PERF_W'(1);
            end
        end
    end

    assign perf_retired = r_perf_retired;
    assign perf_stall   = r_perf_stall;
`else
    assign perf_retired = '0;
    assign perf_stall   = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl_v2.sv
// tb/tb_mc_ctrl_v2.sv - scoreboard bench for mc_ctrl_v2 with randomized instruction streams
module tb_mc_ctrl_v2;

    localparam int TMAX = 4;
    localparam int PW   = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          zero, overflow, MIO_ready;
    logic [31:0]   inst_in;
    logic          MemRead, MemWrite, CPU_MIO, lorD, IRWrite;
    logic          RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch, S;
    logic [1:0]    RegDst, MemtoReg, ALUSrcB, PCSource;
    logic [2:0]    ALU_operation;
    logic [4:0]    state_out;
    logic          exc_valid;
    logic [1:0]    exc_cause;
    logic [PW-1:0] perf_retired, perf_stall;

    always #5 clk = ~clk;

    mc_ctrl_v2 #(.TIMEOUT_W(8), .TIMEOUT_MAX(TMAX), .PERF_W(PW)) dut (
        .clk(clk), .reset(reset), .zero(zero), .overflow(overflow), .MIO_ready(MIO_ready),
        .inst_in(inst_in), .MemRead(MemRead), .MemWrite(MemWrite), .CPU_MIO(CPU_MIO),
        .lorD(lorD), .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch(Branch), .S(S),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .ALU_operation(ALU_operation), .state_out(state_out), .exc_valid(exc_valid),
        .exc_cause(exc_cause), .perf_retired(perf_retired), .perf_stall(perf_stall)
    );

    // One expected clock cycle: inputs to apply plus the outputs they must produce.
    typedef struct {
        logic [31:0] inst;
        bit          mio, ovf, zr;
        int          st;
        bit          rw, mr, mw, pw, pwc, ev;
        int          alu;
        int          pcs;
        int          cause;
    } cyc_t;

    cyc_t        plan[$];
    cyc_t        exp_q[$];
    int          exc_q[$];
    logic [31:0] cur_inst;
    int          checks = 0;
    int          errors = 0;
    int          m_retire = 0;
    int          m_stall = 0;
    bit          mon_en = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic cyc_t mk(input int st);
        cyc_t r;
        r.inst = cur_inst;
        r.mio = 1'b1;
        r.ovf = 1'($urandom_range(0, 1));
        r.zr  = 1'($urandom_range(0, 1));
        r.st = st;
        r.rw = 0; r.mr = 0; r.mw = 0; r.pw = 0; r.pwc = 0; r.ev = 0;
        r.alu = -1; r.pcs = -1; r.cause = 0;
        return r;
    endfunction

    task automatic push_exc(input int cause);
        cyc_t r;
        r = mk(17);
        r.pw = 1; r.ev = 1; r.pcs = 3; r.cause = cause;
        plan.push_back(r);
    endtask

    // A memory access that sees `waits` not-ready cycles; the wait cycle on which
    // TMAX prior waits have already elapsed traps as a bus timeout instead.
    task automatic mem_phase(input int st, input int waits, output bit to);
        cyc_t r;
        to = 0;
        for (int i = 0; i < waits; i++) begin
            r = mk(st);
            r.mio = 0;
            r.mr = (st != 12); r.mw = (st == 12);
            plan.push_back(r);
            m_stall++;
            if (i == TMAX) begin
                push_exc(3);
                to = 1;
                return;
            end
        end
        r = mk(st);
        r.mr = (st != 12); r.mw = (st == 12);
        r.pw = (st == 0);
        plan.push_back(r);
    endtask

    // Encoding table of the ISA: opcode, funct, ALU function, overflow-trapping flag.
    task automatic enc(input int k, output logic [5:0] op, output logic [5:0] fn,
                       output int alu, output bit ar);
        op = 6'h00; fn = 6'h00; alu = -1; ar = 0;
        case (k)
            0:  begin fn = 6'h20; alu = 2; ar = 1; end
            1:  begin fn = 6'h22; alu = 6; ar = 1; end
            2:  begin fn = 6'h24; alu = 0; end
            3:  begin fn = 6'h25; alu = 1; end
            4:  begin fn = 6'h26; alu = 3; end
            5:  begin fn = 6'h27; alu = 4; end
            6:  begin fn = 6'h2A; alu = 7; end
            7:  begin fn = 6'h02; alu = 5; end
            8:  fn = 6'h08;
            9:  fn = 6'h09;
            10: begin op = 6'h08; alu = 2; ar = 1; end
            11: begin op = 6'h0C; alu = 0; end
            12: begin op = 6'h0D; alu = 1; end
            13: begin op = 6'h0E; alu = 3; end
            14: begin op = 6'h0A; alu = 7; end
            15: op = 6'h0F;
            16: op = 6'h23;
            17: op = 6'h2B;
            18: op = 6'h04;
            19: op = 6'h05;
            20: op = 6'h02;
            21: op = 6'h03;
            22: op = 6'h3F;
            default: fn = 6'h3F;
        endcase
    endtask

    task automatic issue(input int k, input int wif, input int wmem, input bit ovf);
        logic [5:0]  op, fn;
        logic [31:0] ins;
        int          alu;
        bit          ar, to;
        cyc_t        r;
        enc(k, op, fn, alu, ar);
        ins = $urandom;
        ins[31:26] = op;
        if (op == 6'h00) ins[5:0] = fn;
        cur_inst = ins;
        mem_phase(0, wif, to);
        if (to) return;
        plan.push_back(mk(1));
        case (k)
            0, 1, 2, 3, 4, 5, 6, 7, 10, 11, 12, 13, 14: begin
                r = mk(k <= 7 ? 2 : 4);
                r.alu = alu;
                if (ar) r.ovf = ovf;
                plan.push_back(r);
                if (ar && ovf) begin
                    push_exc(2);
                end else begin
                    r = mk(k <= 7 ? 13 : 14); r.rw = 1; plan.push_back(r);
                    m_retire++;
                end
            end
            8:  begin r = mk(8);  r.pw = 1; plan.push_back(r); m_retire++; end
            9:  begin r = mk(16); r.pw = 1; r.rw = 1; plan.push_back(r); m_retire++; end
            15: begin r = mk(5);  r.rw = 1; plan.push_back(r); m_retire++; end
            16, 17: begin
                r = mk(3); r.alu = 2; plan.push_back(r);
                mem_phase(k == 16 ? 11 : 12, wmem, to);
                if (!to) begin
                    if (k == 16) begin r = mk(15); r.rw = 1; plan.push_back(r); end
                    m_retire++;
                end
            end
            18, 19: begin
                r = mk(k == 18 ? 6 : 7); r.pwc = 1; r.alu = 6; r.pcs = 1; plan.push_back(r);
                m_retire++;
            end
            20: begin r = mk(10); r.pw = 1; r.pcs = 2; plan.push_back(r); m_retire++; end
            21: begin
                r = mk(9);  r.rw = 1; plan.push_back(r);
                r = mk(10); r.pw = 1; r.pcs = 2; plan.push_back(r);
                m_retire++;
            end
            default: push_exc(1);
        endcase
    endtask

    // Driver: applies one planned cycle per clock and hands its expectation to the scoreboard.
    task automatic run_plan();
        cyc_t r;
        while (plan.size() > 0) begin
            r = plan.pop_front();
            MIO_ready = r.mio; overflow = r.ovf; zero = r.zr; inst_in = r.inst;
            exp_q.push_back(r);
            if (r.ev) exc_q.push_back(r.cause);
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compares the DUT against the oldest pending expectation each cycle.
    initial begin
        cyc_t e;
        forever begin
            @(negedge clk);
            if (mon_en && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk($sformatf("state(exp_st=%0d)", e.st), state_out, e.st);
                chk($sformatf("RegWrite(st=%0d)", e.st), RegWrite, e.rw);
                chk($sformatf("MemRead(st=%0d)", e.st), MemRead, e.mr);
                chk($sformatf("MemWrite(st=%0d)", e.st), MemWrite, e.mw);
                chk($sformatf("PCWrite(st=%0d)", e.st), PCWrite, e.pw);
                chk($sformatf("PCWriteCond(st=%0d)", e.st), PCWriteCond, e.pwc);
                chk($sformatf("exc_valid(st=%0d)", e.st), exc_valid, e.ev);
                if (e.alu >= 0) chk($sformatf("ALU_operation(st=%0d)", e.st), ALU_operation, e.alu);
                if (e.pcs >= 0) chk($sformatf("PCSource(st=%0d)", e.st), PCSource, e.pcs);
            end
            if (mon_en && exc_valid) begin
                if (exc_q.size() == 0) chk("unexpected_exc", 1, 0);
                else chk("exc_cause", exc_cause, exc_q.pop_front());
            end
        end
    end

    initial begin
        bit   to;
        cyc_t r;
        logic [5:0] op, fn;
        int   alu;
        bit   ar;
        reset = 1'b1; MIO_ready = 1'b0; overflow = 1'b0; zero = 1'b0; inst_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", state_out, 0);
        chk("rst_exc_cause", exc_cause, 0);
        chk("rst_exc_valid", exc_valid, 0);
        chk("rst_regwrite", RegWrite, 0);
        chk("rst_perf_retired", perf_retired, 0);
        reset = 1'b0;
        mon_en = 1;

        issue(0, 0, 0, 0);      // add
        issue(1, 0, 0, 0);      // sub
        issue(16, 0, 3, 0);     // lw, three MEM_RD wait cycles
        issue(22, 0, 0, 0);     // opcode 3F
        issue(10, 0, 0, 1);     // addi overflow
        issue(0, 0, 0, 1);      // add overflow
        issue(2, 0, 0, 1);      // and ignores overflow
        issue(17, 0, 9, 0);     // sw, bus timeout
        issue(17, 0, 4, 0);     // sw, ready on the 5th wait cycle
        issue(0, 5, 0, 0);      // fetch timeout
        run_plan();

        for (int n = 0; n < 300; n++) begin
            issue($urandom_range(0, 23),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : 0,
                  ($urandom_range(0, 2) == 0) ? $urandom_range(0, 6) : 0,
                  1'($urandom_range(0, 1)));
            run_plan();
        end

`ifdef MC_CTRL_PERF_EN
        chk("perf_retired", perf_retired, m_retire % (1 << PW));
        chk("perf_stall", perf_stall, m_stall % (1 << PW));
`else
        chk("perf_retired_off", perf_retired, 0);
        chk("perf_stall_off", perf_stall, 0);
`endif

        // Reset during a MEM_WD wait: leave a nonzero cause behind first.
        issue(22, 0, 0, 0);
        enc(17, op, fn, alu, ar);
        cur_inst = $urandom;
        cur_inst[31:26] = op;
        mem_phase(0, 0, to);
        plan.push_back(mk(1));
        r = mk(3); r.alu = 2; plan.push_back(r);
        for (int i = 0; i < 2; i++) begin
            r = mk(12); r.mio = 0; r.mw = 1; plan.push_back(r);
        end
        run_plan();
        mon_en = 0;
        MIO_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("pre_rst_state", state_out, 12);
        chk("pre_rst_memwrite", MemWrite, 1);
        chk("pre_rst_cause", exc_cause, 1);
        @(posedge clk);
        #1;
        chk("post_rst_state", state_out, 0);
        chk("post_rst_memwrite", MemWrite, 0);
        chk("post_rst_cause", exc_cause, 0);
        reset = 1'b0;

        chk("exp_q_drained", exp_q.size(), 0);
        chk("exc_q_drained", exc_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
